led_shift_sequencer: RTL
========================

# led_shift_sequencer

Controller that sequences serial transfers to the LED driver shift registers. It accepts parallel words over a valid/ready handshake and shifts each word out MSB-first on a serial data line. The serial clock is derived internally from the system clock by an even divide factor. After a programmed number of words it issues one latch pulse and signals completion. It sits between the frame/column buffer and the LED driver pins, and owns the divided serial clock for the whole burst.

## Interface

- DIV, 10, serial clock divide factor; even, ≥ 2; one serial bit lasts DIV system cycles.
- WIDTH, 16, bits per input word.
- LEN_W, 8, width of the burst-length field.

Ports:

- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- i_start  in  1  burst request; sampled only in IDLE.
- i_len  in  LEN_W  words in burst; latched with i_start; 0 means the request is ignored.
- i_data  in  WIDTH  word to shift.
- i_valid  in  1  i_data is valid.
- o_ready  out  1  word accepted when i_valid & o_ready.
- o_sclk  out  1  divided serial clock; registered, glitch-free, idles low.
- o_sdata  out  1  serial data, MSB first; registered, 0 outside SHIFT.
- o_latch  out  1  driver latch strobe; high for DIV cycles at the end of the burst.
- o_busy  out  1  high from the cycle after start is accepted until o_done.
- o_done  out  1  one-cycle pulse at burst end.

## Operation

- States: IDLE, WAIT_WORD, SHIFT, LATCH.
- IDLE:
  - All outputs 0.
  - On i_start & (i_len ≠ 0): latch i_len into the words-remaining counter and go to WAIT_WORD.
  - Otherwise stay in IDLE.
- WAIT_WORD:
  - o_ready = 1, o_sclk = 0, o_sdata = 0.
  - On i_valid: load i_data into the shift register, clear the phase and bit counters, and go to SHIFT.
  - With no i_valid, stall indefinitely with no serial clock edges.
- SHIFT:
  - The phase counter runs 0..DIV-1.
  - o_sclk = 1 exactly when phase ≥ DIV/2; o_sdata = current MSB of the shift register.
  - At phase DIV-1, if the bit counter < WIDTH-1: shift left by one, increment the bit counter, and wrap the phase to 0.
  - At phase DIV-1 on the last bit: decrement words-remaining. If the result is 0, go to LATCH; otherwise go to WAIT_WORD.
- LATCH:
  - o_latch = 1, o_sclk = 0, o_sdata = 0, for DIV cycles.
  - Then go to IDLE, with o_done = 1 and o_busy = 0 in that first IDLE cycle.
- o_busy = 1 in WAIT_WORD, SHIFT and LATCH.
- i_start while busy is ignored; no queueing.
- i_start in the o_done cycle is accepted normally, since the block is in IDLE.
- Counter widths:
  - Phase counter: $clog2(DIV) bits.
  - Bit counter: $clog2(WIDTH) bits.
  - Words-remaining: LEN_W bits; max burst 2^LEN_W − 1 words.
- rst asserted in any state: the next edge forces IDLE, clears all counters, and sets every output to 0. Any partial burst is abandoned without a latch pulse.

## Timing

- Reset value of every output is 0.
- i_start accepted at edge k: o_busy = 1 and o_ready = 1 from cycle k+1.
- Word accepted at edge t:
  - o_sdata = bit WIDTH-1 from cycle t+1.
  - o_sclk low for cycles t+1..t+DIV/2 and high for t+DIV/2+1..t+DIV.
  - This pattern repeats per bit; the word occupies WIDTH·DIV cycles.
- o_sdata changes only at sclk falling boundaries (phase wrap), so it is stable across each rising sclk edge.
- Between words there is at least one WAIT_WORD cycle with sclk low. Back-to-back throughput is therefore WIDTH·DIV + 1 cycles per word.
- Last word accepted at edge t:
  - o_latch high for cycles t+WIDTH·DIV+1 .. t+WIDTH·DIV+DIV.
  - o_done high at cycle t+WIDTH·DIV+DIV+1.

## Test plan

All scenarios use DIV=10, WIDTH=16, LEN_W=8.

- **Reset:** hold rst for 3 cycles with i_valid=1 and i_start=1 → all outputs 0 and no sclk edges during reset.
- **Single word:** i_len=1, i_data=0xA5C3, i_valid held, word accepted at edge t →
  - exactly 16 rising o_sclk edges;
  - o_sdata sampled at those edges = 1010010111000011;
  - first rise at cycle t+6, period 10 cycles;
  - o_latch high t+161..t+170; o_done pulse at t+171; o_busy low at t+171.
- **Back-to-back burst:** i_len=3, words 0xFFFF, 0x0000, 0x8001, i_valid held →
  - 48 rising edges;
  - one extra low cycle between words;
  - exactly one latch pulse of 10 cycles, after the 48th bit.
- **Starvation:** i_len=2; after the first word, drop i_valid for 20 cycles →
  - o_sclk stays low and o_ready stays high for those 20 cycles;
  - the second word shifts normally once i_valid returns; still 32 rising edges in total.
- **Ignored starts:**
  - i_start with i_len=0 → o_busy stays 0.
  - i_start pulsed mid-burst → no effect on bit count or latch.
  - i_start in the o_done cycle → a new burst begins on the next cycle.
- **Reset mid-operation:** assert rst during bit 7 of a word → next cycle all outputs 0 and no latch or done pulse follows. A subsequent i_len=1 burst completes correctly.

Source files
------------

// File: rtl/led_shift_sequencer.sv
// led_shift_sequencer
//
// Sequences serial transfers into LED driver shift registers. A burst is
// requested with i_start/i_len. Each word is then taken over a valid/ready
// handshake and shifted out MSB-first. The serial clock is divided from clk
// by DIV. After the last word, one latch strobe DIV cycles wide is issued,
// followed by a single-cycle done pulse.
//
// Every output is registered. Each is decoded from the next-state values so
// that it lines up with the state it describes and never glitches.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   i_start  in   burst request, honoured only when idle
//   i_len    in   words in the burst (0 = request ignored)
//   i_data   in   word to shift
//   i_valid  in   i_data is valid
//   o_ready  out  word accepted when i_valid & o_ready
//   o_sclk   out  divided serial clock, idles low
//   o_sdata  out  serial data, MSB first, 0 outside shifting
//   o_latch  out  driver latch strobe, DIV cycles at burst end
//   o_busy   out  burst in progress
//   o_done   out  one-cycle pulse at burst end
module led_shift_sequencer #(
  parameter int DIV   = 10,
  parameter int WIDTH = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_sclk,
  output logic             o_sdata,
  output logic             o_latch,
  output logic             o_busy,
  output logic             o_done
);

  localparam int PH_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DIV - 1);
  localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_WORD,
    SHIFT,
    LATCH
  } state_t;

  state_t             state_q, state_d;
  logic [PH_W-1:0]    phase_q, phase_d;   // in LATCH this counts strobe cycles
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [LEN_W-1:0]   words_q, words_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic               done_d;

  // Next-state and datapath updates.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    words_d = words_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_start && (i_len != '0)) begin
          words_d = i_len;
          state_d = WAIT_WORD;
        end
      end

      WAIT_WORD: begin
        if (i_valid) begin
          shreg_d = i_data;
          phase_d = '0;
          bit_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (phase_q == PH_LAST) begin
          // The phase wrap is the sclk falling boundary. Data only moves
          // here, so it stays stable across each rising edge.
          phase_d = '0;
          if (bit_q != BIT_LAST) begin
            shreg_d = shreg_q << 1;
            bit_d   = bit_q + 1'b1;
          end else begin
            words_d = words_q - 1'b1;
            state_d = (words_q == LEN_W'(1)) ? LATCH : WAIT_WORD;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      LATCH: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so all registers update together from pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      words_q <= '0;
      shreg_q <= '0;
      o_ready <= 1'b0;
      o_sclk  <= 1'b0;
      o_sdata <= 1'b0;
      o_latch <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      words_q <= words_d;
      shreg_q <= shreg_d;
      o_ready <= (state_d == WAIT_WORD);
      o_sclk  <= (state_d == SHIFT) && (phase_d >= PH_HALF);
      o_sdata <= (state_d == SHIFT) && shreg_d[WIDTH-1];
      o_latch <= (state_d == LATCH);
      o_busy  <= (state_d != IDLE);
      o_done  <= done_d;
    end
  end

endmodule
